instr_issue: RTL and testbench

//   Instruction issue unit: upstream end of the instruction-field interface consumed by the fetch stage.

---
 rtl/instr_issue.sv | 165 ++++++++++++++++
 tb/tb_instr_issue.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/instr_issue.sv
// instr_issue: fetches instruction words over a req/ack memory port, unpacks them and issues fields to fetch; optional issue counter under ISSUE_PERF_CNT_EN
module instr_issue #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [4:0]        HALT_OP    = 5'b11111
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [4:0]        opcode_out,
  output logic [3:0]        s1_out,
  output logic [3:0]        s2_out,
  output logic [3:0]        dest_out,
  output logic [31:0]       ime_data_out,
  output logic              issue_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic [15:0]       issue_count
);
  typedef enum logic [2:0] {IDLE, FETCH_OP, FETCH_IMM, ISSUE, DRAIN, HALT} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ipc_q, ipc_d;
  logic [4:0]        op_q, op_d;
  logic [3:0]        s1_q, s1_d, s2_q, s2_d, dest_q, dest_d;
  logic [31:0]       ime_q, ime_d;
  logic              mem_rd_q, mem_rd_d, iv_q, iv_d, halted_q, halted_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, pc_out_q, pc_out_d;
  logic [4:0]        opcode_out_q, opcode_out_d;
  logic [3:0]        s1_out_q, s1_out_d, s2_out_q, s2_out_d, dest_out_q, dest_out_d;
  logic [31:0]       ime_out_q, ime_out_d;
  // next-state, PC and latched fields; outputs derive from the next state so they are all registered
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    op_d    = op_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dest_d  = dest_q;
    ime_d   = ime_q;
    case (state_q)
      IDLE, HALT: state_d = start ? FETCH_OP : state_q;
      FETCH_OP: begin
        if (branch_en) begin
          pc_d    = branch_addr;
          state_d = mem_ack ? FETCH_OP : DRAIN;
        end else if (mem_ack) begin
          op_d    = mem_rdata[31:27];
          s1_d    = mem_rdata[26:23];
          s2_d    = mem_rdata[22:19];
          dest_d  = mem_rdata[18:15];
          ime_d   = '0;
          ipc_d   = pc_q;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = mem_rdata[14] ? FETCH_IMM : ISSUE;
        end
      end
      FETCH_IMM: begin
        if (branch_en) begin
          pc_d    = branch_addr;
          state_d = mem_ack ? FETCH_OP : DRAIN;
        end else if (mem_ack) begin
          ime_d   = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (branch_en) begin
          pc_d    = branch_addr;
          state_d = FETCH_OP;
        end else if (!stall) begin
          state_d = (op_q == HALT_OP) ? HALT : FETCH_OP;
        end
      end
      DRAIN: begin
        pc_d    = branch_en ? branch_addr : pc_q;
        state_d = mem_ack ? FETCH_OP : DRAIN;
      end
      default: state_d = IDLE;
    endcase
    mem_rd_d     = (state_d == FETCH_OP) || (state_d == FETCH_IMM) || (state_d == DRAIN);
    mem_addr_d   = (mem_rd_d && state_d != DRAIN) ? pc_d : mem_addr_q;
    iv_d         = state_d == ISSUE;
    halted_d     = state_d == HALT;
    opcode_out_d = iv_d ? op_d : '0;
    s1_out_d     = iv_d ? s1_d : '0;
    s2_out_d     = iv_d ? s2_d : '0;
    dest_out_d   = iv_d ? dest_d : '0;
    ime_out_d    = iv_d ? ime_d : '0;
    pc_out_d     = iv_d ? ipc_d : pc_out_q;
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= START_ADDR;
      ipc_q        <= '0;
      op_q         <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      dest_q       <= '0;
      ime_q        <= '0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      iv_q         <= 1'b0;
      halted_q     <= 1'b0;
      opcode_out_q <= '0;
      s1_out_q     <= '0;
      s2_out_q     <= '0;
      dest_out_q   <= '0;
      ime_out_q    <= '0;
      pc_out_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ipc_q        <= ipc_d;
      op_q         <= op_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      dest_q       <= dest_d;
      ime_q        <= ime_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      iv_q         <= iv_d;
      halted_q     <= halted_d;
      opcode_out_q <= opcode_out_d;
      s1_out_q     <= s1_out_d;
      s2_out_q     <= s2_out_d;
      dest_out_q   <= dest_out_d;
      ime_out_q    <= ime_out_d;
      pc_out_q     <= pc_out_d;
    end
  end
  assign mem_rd       = mem_rd_q;
  assign mem_addr     = mem_addr_q;
  assign issue_valid  = iv_q;
  assign halted       = halted_q;
  assign opcode_out   = opcode_out_q;
  assign s1_out       = s1_out_q;
  assign s2_out       = s2_out_q;
  assign dest_out     = dest_out_q;
  assign ime_data_out = ime_out_q;
  assign pc_out       = pc_out_q;
`ifdef ISSUE_PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  // count completed issues (not dropped by a branch), saturating
  always_comb cnt_d = (state_q == ISSUE && !stall && !branch_en && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  // issue counter register, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign issue_count = cnt_q;
`else
  assign issue_count = 16'h0000;
`endif
endmodule

// File: tb/tb_instr_issue.sv
// tb_instr_issue: table-driven cycle vectors plus an async-reset sequence for instr_issue
module tb_instr_issue;
  logic        clk = 0, reset_n = 0;
  logic        start = 0, stall = 0, branch_en = 0, mem_ack = 0;
  logic [7:0]  branch_addr = 0;
  logic [31:0] mem_rdata = 0;
  logic        mem_rd, issue_valid, halted;
  logic [7:0]  mem_addr, pc_out;
  logic [4:0]  opcode_out;
  logic [3:0]  s1_out, s2_out, dest_out;
  logic [31:0] ime_data_out;
  logic [15:0] issue_count;
  int checks = 0, errors = 0;
`ifdef ISSUE_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  instr_issue dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stall(stall), .branch_en(branch_en),
    .branch_addr(branch_addr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .opcode_out(opcode_out), .s1_out(s1_out), .s2_out(s2_out),
    .dest_out(dest_out), .ime_data_out(ime_data_out), .issue_valid(issue_valid),
    .pc_out(pc_out), .halted(halted), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, sl, br; logic [7:0] ba; logic ak; logic [31:0] rd;
    logic erd; logic [7:0] ea; logic eiv; logic [4:0] eop; logic [3:0] es1, es2, ed;
    logic [31:0] eime; logic [7:0] epc; logic eh; logic [15:0] ec;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] a, b, d, input logic imm);
    return {op, a, b, d, imm, 14'b0};
  endfunction

  function automatic vec_t v(input logic st, sl, br, input logic [7:0] ba, input logic ak, input logic [31:0] rd,
                             input logic erd, input logic [7:0] ea, input logic eiv, input logic [4:0] eop,
                             input logic [3:0] es1, es2, ed, input logic [31:0] eime, input logic [7:0] epc,
                             input logic eh, input logic [15:0] ec);
    vec_t r;
    r.st = st; r.sl = sl; r.br = br; r.ba = ba; r.ak = ak; r.rd = rd;
    r.erd = erd; r.ea = ea; r.eiv = eiv; r.eop = eop; r.es1 = es1; r.es2 = es2; r.ed = ed;
    r.eime = eime; r.epc = epc; r.eh = eh; r.ec = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t e);
    chk({tag, ".mem_rd"}, 32'(mem_rd), 32'(e.erd));
    if (e.erd) chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(e.ea));
    chk({tag, ".issue_valid"}, 32'(issue_valid), 32'(e.eiv));
    chk({tag, ".opcode"}, 32'(opcode_out), 32'(e.eop));
    chk({tag, ".s1"}, 32'(s1_out), 32'(e.es1));
    chk({tag, ".s2"}, 32'(s2_out), 32'(e.es2));
    chk({tag, ".dest"}, 32'(dest_out), 32'(e.ed));
    chk({tag, ".ime"}, ime_data_out, e.eime);
    chk({tag, ".pc_out"}, 32'(pc_out), 32'(e.epc));
    chk({tag, ".halted"}, 32'(halted), 32'(e.eh));
    chk({tag, ".count"}, 32'(issue_count), CNT_EN ? 32'(e.ec) : 32'd0);
  endtask

  initial begin
    logic [31:0] w0, w1, w2, w3, wh, w6, wg;
    vec_t z;
    w0 = mk(5'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    w1 = mk(5'd2, 4'd5, 4'd6, 4'd7, 1'b1);
    w2 = mk(5'd3, 4'd1, 4'd1, 4'd1, 1'b0);
    w3 = mk(5'd4, 4'd8, 4'd9, 4'd10, 1'b0);
    wh = mk(5'd31, 4'd0, 4'd0, 4'd0, 1'b0);
    w6 = mk(5'd6, 4'd1, 4'd2, 4'd3, 1'b1);
    wg = mk(5'd7, 4'd7, 4'd7, 4'd7, 1'b0);
    //              st sl br ba     ak rdata        rd addr   iv op  s1 s2 d   ime           pc     h  cnt
    vecs.push_back(v(1, 0, 0, 8'h00, 0, 0,           1, 8'h00, 0, 0,  0, 0, 0,  0,            8'h00, 0, 0));
    vecs.push_back(v(0, 0, 0, 8'h00, 1, w0,          0, 8'h00, 1, 1,  2, 3, 4,  0,            8'h00, 0, 0));
    vecs.push_back(v(0, 0, 0, 8'h00, 0, 0,           1, 8'h01, 0, 0,  0, 0, 0,  0,            8'h00, 0, 1));
    vecs.push_back(v(0, 0, 1, 8'h05, 1, wg,          1, 8'h05, 0, 0,  0, 0, 0,  0,            8'h00, 0, 1));
    vecs.push_back(v(0, 0, 0, 8'h00, 1, w1,          1, 8'h06, 0, 0,  0, 0, 0,  0,            8'h00, 0, 1));
    vecs.push_back(v(0, 0, 0, 8'h00, 1, 32'hDEADBEEF,0, 8'h00, 1, 2,  5, 6, 7,  32'hDEADBEEF, 8'h05, 0, 1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(0, 1, 0, 8'h00, 0, 0,         0, 8'h00, 1, 2,  5, 6, 7,  32'hDEADBEEF, 8'h05, 0, 1));
    vecs.push_back(v(0, 0, 0, 8'h00, 0, 0,           1, 8'h07, 0, 0,  0, 0, 0,  0,            8'h05, 0, 2));
    vecs.push_back(v(0, 0, 0, 8'h00, 1, w2,          0, 8'h00, 1, 3,  1, 1, 1,  0,            8'h07, 0, 2));
    vecs.push_back(v(0, 1, 1, 8'h20, 0, 0,           1, 8'h20, 0, 0,  0, 0, 0,  0,            8'h07, 0, 2));
    vecs.push_back(v(0, 0, 1, 8'h40, 0, 0,           1, 8'h20, 0, 0,  0, 0, 0,  0,            8'h07, 0, 2));
    vecs.push_back(v(0, 0, 0, 8'h00, 0, 0,           1, 8'h20, 0, 0,  0, 0, 0,  0,            8'h07, 0, 2));
    vecs.push_back(v(0, 0, 0, 8'h00, 0, 0,           1, 8'h20, 0, 0,  0, 0, 0,  0,            8'h07, 0, 2));
    vecs.push_back(v(0, 0, 0, 8'h00, 1, wg,          1, 8'h40, 0, 0,  0, 0, 0,  0,            8'h07, 0, 2));
    vecs.push_back(v(0, 0, 1, 8'h10, 0, 0,           1, 8'h40, 0, 0,  0, 0, 0,  0,            8'h07, 0, 2));
    vecs.push_back(v(0, 0, 1, 8'h50, 0, 0,           1, 8'h40, 0, 0,  0, 0, 0,  0,            8'h07, 0, 2));
    vecs.push_back(v(0, 0, 0, 8'h00, 1, wg,          1, 8'h50, 0, 0,  0, 0, 0,  0,            8'h07, 0, 2));
    vecs.push_back(v(0, 1, 0, 8'h00, 0, 0,           1, 8'h50, 0, 0,  0, 0, 0,  0,            8'h07, 0, 2));
    vecs.push_back(v(0, 1, 0, 8'h00, 1, w3,          0, 8'h00, 1, 4,  8, 9, 10, 0,            8'h50, 0, 2));
    vecs.push_back(v(0, 0, 0, 8'h00, 0, 0,           1, 8'h51, 0, 0,  0, 0, 0,  0,            8'h50, 0, 3));
    vecs.push_back(v(0, 0, 1, 8'hFF, 0, 0,           1, 8'h51, 0, 0,  0, 0, 0,  0,            8'h50, 0, 3));
    vecs.push_back(v(0, 0, 0, 8'h00, 1, wg,          1, 8'hFF, 0, 0,  0, 0, 0,  0,            8'h50, 0, 3));
    vecs.push_back(v(0, 0, 0, 8'h00, 1, wh,          0, 8'h00, 1, 31, 0, 0, 0,  0,            8'hFF, 0, 3));
    vecs.push_back(v(0, 0, 0, 8'h00, 0, 0,           0, 8'h00, 0, 0,  0, 0, 0,  0,            8'hFF, 1, 4));
    vecs.push_back(v(0, 0, 0, 8'h00, 0, 0,           0, 8'h00, 0, 0,  0, 0, 0,  0,            8'hFF, 1, 4));
    vecs.push_back(v(0, 0, 1, 8'h33, 0, 0,           0, 8'h00, 0, 0,  0, 0, 0,  0,            8'hFF, 1, 4));
    vecs.push_back(v(1, 0, 0, 8'h00, 0, 0,           1, 8'h00, 0, 0,  0, 0, 0,  0,            8'hFF, 0, 4));
    vecs.push_back(v(0, 0, 1, 8'hFF, 1, wg,          1, 8'hFF, 0, 0,  0, 0, 0,  0,            8'hFF, 0, 4));
    vecs.push_back(v(0, 0, 0, 8'h00, 1, w6,          1, 8'h00, 0, 0,  0, 0, 0,  0,            8'hFF, 0, 4));
    vecs.push_back(v(0, 0, 0, 8'h00, 1, 32'h12345678,0, 8'h00, 1, 6,  1, 2, 3,  32'h12345678, 8'hFF, 0, 4));
    vecs.push_back(v(0, 0, 0, 8'h00, 0, 0,           1, 8'h01, 0, 0,  0, 0, 0,  0,            8'hFF, 0, 5));

    z = v(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    #12;
    chk_all("reset", z);
    @(negedge clk);
    reset_n = 1;

    foreach (vecs[i]) begin
      start = vecs[i].st; stall = vecs[i].sl; branch_en = vecs[i].br; branch_addr = vecs[i].ba;
      mem_ack = vecs[i].ak; mem_rdata = vecs[i].rd;
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), vecs[i]);
    end

    start = 0; stall = 0; branch_en = 0; mem_ack = 1; mem_rdata = w6;
    @(posedge clk);
    #1;
    mem_ack = 0; mem_rdata = 0;
    chk("fimm.mem_rd", 32'(mem_rd), 32'd1);
    chk("fimm.mem_addr", 32'(mem_addr), 32'h02);
    #2;
    reset_n = 0;
    #1;
    z.ec = 0;
    chk_all("async_rst", z);
    @(negedge clk);
    reset_n = 1;
    mem_ack = 1; mem_rdata = w0;
    @(posedge clk);
    #1;
    mem_ack = 0;
    chk_all("late_ack_idle", z);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    chk("restart.mem_rd", 32'(mem_rd), 32'd1);
    chk("restart.mem_addr", 32'(mem_addr), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
